// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch stage with register scoreboard; optional same-cycle writeback bypass under OPERAND_FETCH_BYPASS_EN
module operand_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [4:0]  i_rd,
    input  logic        i_use_rs1,
    input  logic        i_use_rs2,
    input  logic        i_wr_rd,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm,
    output logic        o_arf_re,
    output logic [4:0]  o_arf_rs1,
    output logic [4:0]  o_arf_rs2,
    input  logic [31:0] i_arf_data1,
    input  logic [31:0] i_arf_data2,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    input  logic        i_flush,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    output logic [31:0] o_pc,
    output logic [31:0] o_imm,
    output logic [4:0]  o_rd,
    output logic        o_wr_rd
);

    // Bit 0 of the scoreboard is kept at zero so x0 is never busy.
    logic [31:0] sb_q, sb_d;
    logic        valid_q, valid_d;
    logic [31:0] rs1_data_q, rs1_data_d;
    logic [31:0] rs2_data_q, rs2_data_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] imm_q, imm_d;
    logic [4:0]  rd_q, rd_d;
    logic        wr_rd_q, wr_rd_d;

    logic [31:0] busy_vec;
    logic [31:0] wb_mask;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic        hazard;
    logic        fire;
    logic [31:0] op1;
    logic [31:0] op2;

    // Register-file read port follows decode directly.
    assign o_arf_re  = i_valid;
    assign o_arf_rs1 = i_rs1;
    assign o_arf_rs2 = i_rs2;

    assign o_valid    = valid_q;
    assign o_rs1_data = rs1_data_q;
    assign o_rs2_data = rs2_data_q;
    assign o_pc       = pc_q;
    assign o_imm      = imm_q;
    assign o_rd       = rd_q;
    assign o_wr_rd    = wr_rd_q;

    // Hazard detection and handshake; a writeback landing this cycle only unblocks with bypass.
    always_comb begin
        wb_mask = 32'd0;
        if (i_wb_valid && (i_wb_rd != 5'd0)) begin
            wb_mask = 32'd1 << i_wb_rd;
        end
`ifdef OPERAND_FETCH_BYPASS_EN
        busy_vec = sb_q & ~wb_mask;
`else
        busy_vec = sb_q;
`endif
        hazard = (i_use_rs1 && (i_rs1 != 5'd0) && busy_vec[i_rs1]) ||
                 (i_use_rs2 && (i_rs2 != 5'd0) && busy_vec[i_rs2]) ||
                 (i_wr_rd   && (i_rd  != 5'd0) && busy_vec[i_rd]);
        o_ready = !i_flush && !hazard && (!valid_q || i_ready);
        fire    = i_valid && o_ready;
    end

    // Operand selection: x0 reads as zero, optionally forwarding the writeback value.
    always_comb begin
        op1 = i_arf_data1;
        op2 = i_arf_data2;
`ifdef OPERAND_FETCH_BYPASS_EN
        if (i_wb_valid && (i_wb_rd == i_rs1)) begin
            op1 = i_wb_data;
        end
        if (i_wb_valid && (i_wb_rd == i_rs2)) begin
            op2 = i_wb_data;
        end
`endif
        if (i_rs1 == 5'd0) begin
            op1 = 32'd0;
        end
        if (i_rs2 == 5'd0) begin
            op2 = 32'd0;
        end
    end

    // Scoreboard update: set on issue of a writer, cleared by writeback or by killing a held writer; set wins.
    always_comb begin
        set_mask = 32'd0;
        clr_mask = wb_mask;
        if (fire && i_wr_rd && (i_rd != 5'd0)) begin
            set_mask = 32'd1 << i_rd;
        end
        if (i_flush && valid_q && wr_rd_q && (rd_q != 5'd0)) begin
            clr_mask = clr_mask | (32'd1 << rd_q);
        end
        sb_d = ((sb_q & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
    end

    // Output register next state: load on fire, hold while stalled, drop on flush or consumption.
    always_comb begin
        valid_d    = valid_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        rd_d       = rd_q;
        wr_rd_d    = wr_rd_q;
        if (fire) begin
            valid_d    = 1'b1;
            rs1_data_d = op1;
            rs2_data_d = op2;
            pc_d       = i_pc;
            imm_d      = i_imm;
            rd_d       = i_rd;
            wr_rd_d    = i_wr_rd;
        end else if (i_flush || i_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q       <= 32'd0;
            valid_q    <= 1'b0;
            rs1_data_q <= 32'd0;
            rs2_data_q <= 32'd0;
            pc_q       <= 32'd0;
            imm_q      <= 32'd0;
            rd_q       <= 5'd0;
            wr_rd_q    <= 1'b0;
        end else begin
            sb_q       <= sb_d;
            valid_q    <= valid_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            rd_q       <= rd_d;
            wr_rd_q    <= wr_rd_d;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed scoreboard bench for operand_fetch
module tb_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [4:0]  i_rs1, i_rs2, i_rd;
    logic        i_use_rs1, i_use_rs2, i_wr_rd;
    logic [31:0] i_pc, i_imm;
    logic        o_arf_re;
    logic [4:0]  o_arf_rs1, o_arf_rs2;
    logic [31:0] i_arf_data1, i_arf_data2;
    logic        i_wb_valid;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_data;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_rs1_data, o_rs2_data, o_pc, o_imm;
    logic [4:0]  o_rd;
    logic        o_wr_rd;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wr;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        last;
    logic [31:0] regs [32];
    int          checks;
    int          failures;

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
        .i_use_rs1(i_use_rs1), .i_use_rs2(i_use_rs2), .i_wr_rd(i_wr_rd),
        .i_pc(i_pc), .i_imm(i_imm),
        .o_arf_re(o_arf_re), .o_arf_rs1(o_arf_rs1), .o_arf_rs2(o_arf_rs2),
        .i_arf_data1(i_arf_data1), .i_arf_data2(i_arf_data2),
        .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
        .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
        .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_pc(o_pc), .o_imm(o_imm),
        .o_rd(o_rd), .o_wr_rd(o_wr_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: x0 returns junk so the stage must force zero itself.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h1000 + i;
            regs[0] <= 32'hDEAD_BEEF;
        end else if (i_wb_valid && i_wb_rd != 5'd0) begin
            regs[i_wb_rd] <= i_wb_data;
        end
    end
    assign i_arf_data1 = regs[i_rs1];
    assign i_arf_data2 = regs[i_rs2];

    function automatic logic [31:0] opnd(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : regs[r];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic wr,
                       input logic [31:0] pc, input logic [31:0] imm);
        i_valid = v; i_rs1 = rs1; i_rs2 = rs2; i_rd = rd;
        i_use_rs1 = u1; i_use_rs2 = u2; i_wr_rd = wr; i_pc = pc; i_imm = imm;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [4:0] rd, input logic wr);
        rec_t r;
        r.rs1 = a; r.rs2 = b; r.pc = pc; r.imm = imm; r.rd = rd; r.wr = wr;
        exp_q.push_back(r);
    endtask

    task automatic expect_out(input string tag);
        rec_t r;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            r = exp_q.pop_front();
            chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
            chk({tag, "_rs1"}, o_rs1_data, r.rs1);
            chk({tag, "_rs2"}, o_rs2_data, r.rs2);
            chk({tag, "_pc"}, o_pc, r.pc);
            chk({tag, "_imm"}, o_imm, r.imm);
            chk({tag, "_rd"}, {27'd0, o_rd}, {27'd0, r.rd});
            chk({tag, "_wr"}, {31'd0, o_wr_rd}, {31'd0, r.wr});
            last = r;
        end
    endtask

    // Consumer of rs1=rd is stalled; release it with a writeback of data to rd.
    task automatic wb_release(input string tag, input logic [4:0] rd, input logic [31:0] data,
                              input logic [31:0] exp_rs2, input logic [4:0] exp_rd, input logic exp_wr);
        i_wb_valid = 1'b1; i_wb_rd = rd; i_wb_data = data;
        #1;
`ifdef OPERAND_FETCH_BYPASS_EN
        chk({tag, "_ready_wb"}, {31'd0, o_ready}, 32'd1);
        push(data, exp_rs2, i_pc, i_imm, exp_rd, exp_wr);
        tick();
        i_wb_valid = 1'b0;
        expect_out(tag);
`else
        chk({tag, "_ready_wb"}, {31'd0, o_ready}, 32'd0);
        tick();
        i_wb_valid = 1'b0;
        #1;
        chk({tag, "_ready_after"}, {31'd0, o_ready}, 32'd1);
        push(opnd(i_rs1), exp_rs2, i_pc, i_imm, exp_rd, exp_wr);
        tick();
        expect_out(tag);
`endif
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        i_ready = 1'b0; i_flush = 1'b0;
        i_wb_valid = 1'b0; i_wb_rd = 5'd0; i_wb_data = 32'd0;
        drv(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
        #2;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_rs1", o_rs1_data, 32'd0);
        chk("rst_rd", {27'd0, o_rd}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        i_ready = 1'b1;

        // First producer: addi x5
        drv(1, 5'd1, 5'd0, 5'd5, 1, 0, 1, 32'h100, 32'h5);
        #1;
        chk("s1_ready", {31'd0, o_ready}, 32'd1);
        chk("s1_arf_re", {31'd0, o_arf_re}, 32'd1);
        chk("s1_arf_rs1", {27'd0, o_arf_rs1}, 32'd1);
        push(opnd(5'd1), 32'd0, 32'h100, 32'h5, 5'd5, 1'b1);
        tick();
        expect_out("s1");

        // RAW on x5 stalls until writeback
        drv(1, 5'd5, 5'd2, 5'd6, 1, 1, 0, 32'h104, 32'h8);
        #1;
        chk("s2_ready_stall", {31'd0, o_ready}, 32'd0);
        tick();
        chk("s2_valid_drop", {31'd0, o_valid}, 32'd0);
        wb_release("s2", 5'd5, 32'h1234, opnd(5'd2), 5'd6, 1'b0);

        // Downstream backpressure holds the output stable
        i_ready = 1'b0;
        drv(1, 5'd3, 5'd4, 5'd8, 1, 1, 0, 32'h108, 32'h10);
        #1;
        chk("s3_ready_bp", {31'd0, o_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s3_hold_valid", {31'd0, o_valid}, 32'd1);
            chk("s3_hold_pc", o_pc, last.pc);
            chk("s3_hold_rs1", o_rs1_data, last.rs1);
            i_valid = i[0];
            #1;
            chk("s3_hold_ready", {31'd0, o_ready}, 32'd0);
        end
        i_ready = 1'b1;
        drv(1, 5'd3, 5'd4, 5'd8, 1, 1, 0, 32'h108, 32'h10);
        #1;
        chk("s3_ready_go", {31'd0, o_ready}, 32'd1);
        push(opnd(5'd3), opnd(5'd4), 32'h108, 32'h10, 5'd8, 1'b0);
        tick();
        expect_out("s3");

        // Flush kills held writer of x7 and frees its scoreboard bit
        drv(1, 5'd0, 5'd0, 5'd7, 0, 0, 1, 32'h10C, 32'h20);
        #1;
        chk("s4_ready", {31'd0, o_ready}, 32'd1);
        push(32'd0, 32'd0, 32'h10C, 32'h20, 5'd7, 1'b1);
        tick();
        expect_out("s4");
        i_ready = 1'b0;
        i_flush = 1'b1;
        drv(1, 5'd7, 5'd0, 5'd9, 1, 0, 1, 32'h110, 32'h0);
        #1;
        chk("s4_ready_flush", {31'd0, o_ready}, 32'd0);
        tick();
        i_flush = 1'b0;
        chk("s4_valid_flush", {31'd0, o_valid}, 32'd0);
        #1;
        chk("s4_ready_x7_free", {31'd0, o_ready}, 32'd1);
        push(opnd(5'd7), 32'd0, 32'h110, 32'h0, 5'd9, 1'b1);
        tick();
        expect_out("s4b");
        i_ready = 1'b1;

        // Set beats clear for x3 in the same cycle
        drv(1, 5'd1, 5'd0, 5'd3, 1, 0, 1, 32'h114, 32'h30);
        i_wb_valid = 1'b1; i_wb_rd = 5'd3; i_wb_data = 32'h5555;
        #1;
        chk("s5_ready", {31'd0, o_ready}, 32'd1);
        push(opnd(5'd1), 32'd0, 32'h114, 32'h30, 5'd3, 1'b1);
        tick();
        i_wb_valid = 1'b0;
        expect_out("s5");
        drv(1, 5'd3, 5'd0, 5'd0, 1, 0, 0, 32'h118, 32'h34);
        #1;
        chk("s5_ready_x3_busy", {31'd0, o_ready}, 32'd0);
        tick();
        chk("s5_valid_drop", {31'd0, o_valid}, 32'd0);
        wb_release("s5b", 5'd3, 32'h7777, 32'd0, 5'd0, 1'b0);

        // x0 as destination and source: no stall, zero operand
        drv(1, 5'd0, 5'd0, 5'd0, 1, 1, 1, 32'h11C, 32'h40);
        #1;
        chk("s6_ready", {31'd0, o_ready}, 32'd1);
        push(32'd0, 32'd0, 32'h11C, 32'h40, 5'd0, 1'b1);
        tick();
        expect_out("s6");
        drv(1, 5'd0, 5'd2, 5'd0, 1, 1, 1, 32'h120, 32'h44);
        #1;
        chk("s6_ready_x0", {31'd0, o_ready}, 32'd1);
        push(32'd0, opnd(5'd2), 32'h120, 32'h44, 5'd0, 1'b1);
        tick();
        expect_out("s6b");

        // Reset during a stall discards the held writer and its scoreboard bit
        drv(1, 5'd1, 5'd0, 5'd10, 1, 0, 1, 32'h124, 32'h50);
        #1;
        chk("s7_ready", {31'd0, o_ready}, 32'd1);
        push(opnd(5'd1), 32'd0, 32'h124, 32'h50, 5'd10, 1'b1);
        tick();
        expect_out("s7");
        i_ready = 1'b0;
        i_valid = 1'b0;
        tick();
        chk("s7_held", {31'd0, o_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("s7_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("s7_rst_pc", o_pc, 32'd0);
        chk("s7_rst_imm", o_imm, 32'd0);
        chk("s7_rst_rd", {27'd0, o_rd}, 32'd0);
        chk("s7_rst_wr", {31'd0, o_wr_rd}, 32'd0);
        chk("s7_rst_rs2", o_rs2_data, 32'd0);
        tick();
        rst_n = 1'b1;
        drv(1, 5'd10, 5'd9, 5'd11, 1, 1, 0, 32'h200, 32'h60);
        #1;
        chk("s7_ready_after_rst", {31'd0, o_ready}, 32'd1);
        push(opnd(5'd10), opnd(5'd9), 32'h200, 32'h60, 5'd11, 1'b0);
        tick();
        expect_out("s7b");
        i_valid = 1'b0;

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
